// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//   Bundles the two requester handshakes and the RAM-side bus of the shared
//   256x8 data RAM arbiter into one interface.
//
//   Requester 0 (CPU core) / requester 1 (DMA / peripheral engine):
//     reqN    access request, held until ackN
//     weN     1 = write, 0 = read
//     addrN   access address
//     wdataN  write data
//     ackN    one-cycle completion pulse
//     rdataN  read data, valid with ackN and held afterwards
//     err1    pulses with ack1 when a protected requester-1 write was dropped
//
//   RAM side:
//     ram_a   RAM address (registered)
//     ram_dd  RAM write data (registered)
//     ram_wr  RAM write strobe (registered, one cycle wide)
//     ram_d   RAM asynchronous read data
//
//   Modports:
//     slave   the arbiter
//     master  the environment: both requesters plus the RAM itself
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;
  logic          err1;

  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_dd;
  logic          ram_wr;
  logic [DW-1:0] ram_d;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1, err1,
    output ram_a, ram_dd, ram_wr,
    input  ram_d
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1, err1,
    input  ram_a, ram_dd, ram_wr,
    output ram_d
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares the single-ported 256x8 data RAM between requester 0 (CPU core)
//   and requester 1 (DMA / peripheral engine). Accesses are serialised through
//   a four-state FSM (IDLE -> SETUP -> [STROBE] -> ACK -> IDLE) that drives
//   registered address, write data and a glitch-free one-cycle write strobe.
//   The RAM captures data on the rising edge of ram_wr, so address and data
//   are held for one full cycle before (SETUP) and after (ACK) the strobe.
//
//   Optionally (PROTECT_PORTS=1) requester-1 writes into the I/O port window
//   PORT_BASE..all-ones are dropped: no strobe, ack1 pulses together with err1.
//
//   Ports:
//     clk   system clock, all state changes on its rising edge
//     rst   synchronous active-high reset
//     bus   ram_port_arbiter_if.slave: both requester handshakes and RAM bus
//
//   Timing from the edge that samples req in IDLE:
//     read  : ack after 2 edges, one access per 3 cycles
//     write : ack after 3 edges, one access per 4 cycles
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int            AW            = 8,
  parameter int            DW            = 8,
  parameter logic [AW-1:0] PORT_BASE     = 8'hFC,
  parameter bit            PROTECT_PORTS = 1'b1
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t        state;
  logic          gnt_q;      // id of the requester currently being served
  logic          we_q;       // latched direction of the current access
  logic          last_gnt;   // id served most recently, for round-robin ties
  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] ram_dd_q;
  logic          ram_wr_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          err1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Unsigned compare; the window runs up to all-ones with no wrap.
  function automatic logic in_port_window(input logic [AW-1:0] a);
    return (a >= PORT_BASE);
  endfunction

  // Grant choice in IDLE. On a tie the requester not served last wins;
  // last_gnt resets to 1 so requester 0 wins the very first tie.
  logic pick;
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last_gnt;
    else                      pick = bus.req1;
  end

  // Only requester-1 writes can be dropped; reads and requester 0 never are.
  logic blocked;
  assign blocked = PROTECT_PORTS && gnt_q && in_port_window(ram_a_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      last_gnt <= 1'b1;
      ram_a_q  <= '0;
      ram_dd_q <= '0;
      ram_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // Pulse outputs default low; each is raised only on entry to the one
      // state in which it is meant to be high, so it lasts exactly one cycle.
      ram_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err1_q   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_q <= pick;
            if (pick) begin
              we_q     <= bus.we1;
              ram_a_q  <= bus.addr1;
              ram_dd_q <= bus.wdata1;
            end else begin
              we_q     <= bus.we0;
              ram_a_q  <= bus.addr0;
              ram_dd_q <= bus.wdata0;
            end
            state <= SETUP;
          end
        end

        // Address and data have been stable since the grant edge.
        SETUP: begin
          if (we_q) begin
            if (blocked) begin
              ack1_q <= 1'b1;
              err1_q <= 1'b1;
              state  <= ACK;
            end else begin
              ram_wr_q <= 1'b1;
              state    <= STROBE;
            end
          end else begin
            if (gnt_q) begin
              rdata1_q <= bus.ram_d;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= bus.ram_d;
              ack0_q   <= 1'b1;
            end
            state <= ACK;
          end
        end

        // ram_wr is high for this whole cycle; address/data stay held in ACK.
        STROBE: begin
          if (gnt_q) ack1_q <= 1'b1;
          else       ack0_q <= 1'b1;
          state <= ACK;
        end

        ACK: begin
          last_gnt <= gnt_q;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_a  = ram_a_q;
  assign bus.ram_dd = ram_dd_q;
  assign bus.ram_wr = ram_wr_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.err1   = err1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule
